// File: rtl/pattern_round_ctrl.sv
// Game round controller: fetches a random word from the LFSR, shows a stage-masked pattern,
// then collects and grades the player's switch answer until MAX_STAGE is cleared or a miss.
module pattern_round_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned INPUT_CYCLES   = 250_000_000,
  parameter int unsigned BITS_PER_STAGE = 4,
  parameter int unsigned MAX_STAGE      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        submit,
  input  logic [15:0] sw,
  input  logic [15:0] rand_in,
  input  logic        has_generated,
  output logic        next_stage,
  output logic [15:0] led,
  output logic [3:0]  stage_num,
  output logic        busy,
  output logic        pass_pulse,
  output logic        win,
  output logic        lose
);

  localparam int unsigned TimerMax = (SHOW_CYCLES > INPUT_CYCLES) ? SHOW_CYCLES : INPUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  typedef logic [TimerW-1:0] timer_t;

  localparam timer_t ShowLast  = timer_t'(SHOW_CYCLES - 1);
  localparam timer_t InputLast = timer_t'(INPUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StLatch, StShow, StInput, StGrade, StWin, StLose
  } state_e;

  function automatic logic [15:0] stage_mask(input logic [3:0] k);
    logic [31:0] bits;
    bits = 32'(k) * BITS_PER_STAGE;
    if (bits >= 32'd16) return 16'hFFFF;
    return 16'((32'd1 << bits) - 32'd1);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  stage_q, stage_d;
  logic [15:0] pattern_q, pattern_d;
  logic [15:0] answer_q, answer_d;
  timer_t      timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic        next_stage_q, next_stage_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic [15:0] mask;

  assign mask = stage_mask(stage_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      stage_q      <= 4'd0;
      pattern_q    <= 16'h0;
      answer_q     <= 16'h0;
      timer_q      <= '0;
      led_q        <= 16'h0;
      next_stage_q <= 1'b0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      pattern_q    <= pattern_d;
      answer_q     <= answer_d;
      timer_q      <= timer_d;
      led_q        <= led_d;
      next_stage_q <= next_stage_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    pattern_d    = pattern_q;
    answer_d     = answer_q;
    timer_d      = timer_q;
    led_d        = led_q;
    next_stage_d = next_stage_q;
    pass_d       = 1'b0;
    win_d        = win_q;
    lose_d       = lose_q;

    unique case (state_q)
      StIdle, StWin, StLose: begin
        next_stage_d = 1'b0;
        led_d        = 16'h0;
        if (start) begin
          state_d      = StReq;
          stage_d      = 4'd1;
          win_d        = 1'b0;
          lose_d       = 1'b0;
          next_stage_d = 1'b1;
        end
      end
      StReq: begin
        next_stage_d = 1'b1;
        if (has_generated) state_d = StLatch;
      end
      StLatch: begin
        // LFSR is still frozen during this cycle, so rand_in is the handed-over word.
        pattern_d    = rand_in & mask;
        led_d        = rand_in & mask;
        next_stage_d = 1'b0;
        timer_d      = '0;
        state_d      = StShow;
      end
      StShow: begin
        if (timer_q == ShowLast) begin
          state_d = StInput;
          led_d   = 16'h0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + timer_t'(1);
        end
      end
      StInput: begin
        // A submit on the final allowed cycle takes priority over the timeout.
        if (submit) begin
          answer_d = sw & mask;
          state_d  = StGrade;
        end else if (timer_q == InputLast) begin
          state_d = StLose;
          lose_d  = 1'b1;
        end else begin
          timer_d = timer_q + timer_t'(1);
        end
      end
      StGrade: begin
        if (answer_q == pattern_q) begin
          pass_d = 1'b1;
          if (stage_q == 4'(MAX_STAGE)) begin
            state_d = StWin;
            win_d   = 1'b1;
          end else begin
            stage_d      = stage_q + 4'd1;
            state_d      = StReq;
            next_stage_d = 1'b1;
          end
        end else begin
          state_d = StLose;
          lose_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = !(state_d inside {StIdle, StWin, StLose});
  end

  assign next_stage = next_stage_q;
  assign led        = led_q;
  assign stage_num  = stage_q;
  assign busy       = busy_q;
  assign pass_pulse = pass_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule
